fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_ctrl_pc_reg.sv | 38 +++
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// Fetch program counter: synchronous reset, redirect load, sequential increment.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        inc,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d = pc_q + 32'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, one held
// instruction, branch redirect with kill of in-flight requests.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] b_addr,
  input  logic        z,
  input  logic        b,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] pc
);

  state_e      state_d, state_q;
  logic [31:0] tgt_d, tgt_q;
  logic [31:0] inst_d, inst_q;
  logic [31:0] inst_pc_d, inst_pc_q;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic        pc_inc;
  logic        redirect;
  logic [31:0] target;

  assign redirect = b & z;
  assign target   = align_word(b_addr);

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    pc_load      = 1'b0;
    pc_load_addr = target;
    pc_inc       = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        pc_load = redirect;
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_load = 1'b1;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc;
            state_d   = HOLD;
          end
        end else if (redirect) begin
          tgt_d   = target;
          state_d = KILL;
        end
      end
      KILL: begin
        if (redirect) begin
          tgt_d = target;
        end
        // A redirect coinciding with the ack is the newest target and wins.
        if (imem_ack) begin
          pc_load      = 1'b1;
          pc_load_addr = redirect ? target : tgt_q;
          state_d      = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          state_d = REQ;
        end else if (inst_ready) begin
          pc_inc  = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign imem_req   = (state_q == REQ) || (state_q == KILL);
  assign imem_addr  = pc;
  assign inst_valid = (state_q == HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] b_addr;
  logic        z;
  logic        b;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] pc;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: request outstanding / being killed / instruction held.
  logic        m_started, m_busy, m_kill, m_have;
  logic [31:0] m_pc, m_tgt, m_inst, m_ipc;

  fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .b_addr     (b_addr),
    .z          (z),
    .b          (b),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [31:0] t;
    logic        redir;
    t     = b_addr & 32'hFFFF_FFFC;
    redir = (b == 1'b1) && (z == 1'b1);
    if (reset) begin
      m_started = 0; m_busy = 0; m_kill = 0; m_have = 0;
      m_pc = 32'h0; m_tgt = 32'h0; m_inst = 32'h0; m_ipc = 32'h0;
    end else if (!m_started) begin
      m_started = 1; m_busy = 1;
      if (redir) m_pc = t;
    end else if (m_busy) begin
      if (imem_ack) begin
        if (m_kill) begin
          m_pc = redir ? t : m_tgt;
          m_kill = 0;
        end else if (redir) begin
          m_pc = t;
        end else begin
          m_inst = imem_rdata; m_ipc = m_pc; m_have = 1; m_busy = 0;
        end
      end else if (redir) begin
        m_tgt = t; m_kill = 1;
      end
    end else if (m_have) begin
      if (redir) begin
        m_have = 0; m_busy = 1; m_pc = t;
      end else if (inst_ready) begin
        m_have = 0; m_busy = 1; m_pc = m_ipc + 32'd4;
      end
    end
  endtask

  task automatic tick(input logic r, input logic bb, input logic zz, input logic [31:0] ba,
                      input logic ak, input logic [31:0] rd, input logic rdy);
    reset = r; b = bb; z = zz; b_addr = ba; imem_ack = ak; imem_rdata = rd; inst_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Reset, then fetch n instructions back to back; ends in REQ at 4*n.
  task automatic go_req(input int unsigned n);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    for (int unsigned k = 0; k < n; k++) begin
      tick(0, 0, 0, 0, 1, 32'(k * 4), 1);
      tick(0, 0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_reset();
    tick(1, 1, 1, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF, 1);
    n_total++;
    if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else n_pass++;
    n_total++;
    if (inst_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", inst_valid); else n_pass++;
    n_total++;
    if (pc !== 32'h0) $display("FAIL reset_pc got %h want 0", pc); else n_pass++;
    n_total++;
    if (inst !== 32'h0) $display("FAIL reset_inst got %h want 0", inst); else n_pass++;
    n_total++;
    if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc got %h want 0", inst_pc); else n_pass++;
    tick(0, 0, 0, 0, 1, 32'h5555_5555, 1);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0)
      $display("FAIL reset_first_req got req=%b addr=%h valid=%b want 1/0/0", imem_req, imem_addr, inst_valid);
    else n_pass++;
  endtask

  task automatic test_sequential();
    go_req(0);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL seq_start got req=%b addr=%h want 1/0", imem_req, imem_addr);
    else n_pass++;
    for (int unsigned k = 0; k < 4; k++) begin
      tick(0, 0, 0, 0, 1, 32'(k * 4), 1);
      n_total++;
      if (inst_valid !== 1'b1 || inst !== 32'(k * 4) || inst_pc !== 32'(k * 4) || imem_req !== 1'b0)
        $display("FAIL seq_capture%0d got valid=%b inst=%h inst_pc=%h req=%b want 1/%h/%h/0",
                 k, inst_valid, inst, inst_pc, imem_req, 32'(k * 4), 32'(k * 4));
      else n_pass++;
      tick(0, 0, 0, 0, 0, 0, 1);
      n_total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'((k + 1) * 4) || inst_valid !== 1'b0)
        $display("FAIL seq_next%0d got req=%b addr=%h valid=%b want 1/%h/0",
                 k, imem_req, imem_addr, inst_valid, 32'((k + 1) * 4));
      else n_pass++;
    end
  endtask

  task automatic test_delayed_ack();
    go_req(2);
    for (int unsigned i = 0; i < 4; i++) begin
      n_total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b0)
        $display("FAIL delay_hold%0d got req=%b addr=%h valid=%b want 1/8/0", i, imem_req, imem_addr, inst_valid);
      else n_pass++;
      if (i < 3) tick(0, 0, 0, 0, 0, 32'hBAD0_0000, 1);
    end
    tick(0, 0, 0, 0, 1, 32'h8, 0);
    n_total++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst !== 32'h8)
      $display("FAIL delay_capture got valid=%b inst_pc=%h inst=%h want 1/8/8", inst_valid, inst_pc, inst);
    else n_pass++;
  endtask

  task automatic test_redirect_hold();
    go_req(1);
    tick(0, 0, 0, 0, 1, 32'h4, 0);
    tick(0, 1, 1, 32'h23, 0, 0, 1);
    n_total++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20)
      $display("FAIL redir_hold got valid=%b req=%b addr=%h want 0/1/20", inst_valid, imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_redirect_kill();
    go_req(0);
    tick(0, 1, 1, 32'h10, 0, 0, 1);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL kill_stable got req=%b addr=%h want 1/0", imem_req, imem_addr);
    else n_pass++;
    tick(0, 1, 1, 32'h40, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0)
      $display("FAIL kill_wait got req=%b addr=%h valid=%b want 1/0/0", imem_req, imem_addr, inst_valid);
    else n_pass++;
    tick(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    n_total++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40 || inst !== 32'h0)
      $display("FAIL kill_done got valid=%b req=%b addr=%h inst=%h want 0/1/40/0",
               inst_valid, imem_req, imem_addr, inst);
    else n_pass++;
  endtask

  task automatic test_no_effect_and_wrap();
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 32'h300, 0, 0, 1);
    tick(0, 0, 1, 32'h300, 0, 0, 1);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL noeff_req got req=%b addr=%h want 1/0", imem_req, imem_addr);
    else n_pass++;
    tick(0, 1, 0, 32'h300, 1, 32'h77, 1);
    tick(0, 0, 1, 32'h300, 0, 0, 0);
    n_total++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h77)
      $display("FAIL noeff_hold got valid=%b inst_pc=%h inst=%h want 1/0/77", inst_valid, inst_pc, inst);
    else n_pass++;
    tick(0, 1, 0, 32'h300, 0, 0, 1);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4)
      $display("FAIL noeff_next got req=%b addr=%h want 1/4", imem_req, imem_addr);
    else n_pass++;
    tick(0, 1, 1, 32'h81, 0, 0, 1);
    tick(0, 1, 0, 32'h100, 0, 0, 1);
    tick(0, 0, 1, 32'h100, 1, 32'h99, 1);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80 || inst_valid !== 1'b0)
      $display("FAIL noeff_kill got req=%b addr=%h valid=%b want 1/80/0", imem_req, imem_addr, inst_valid);
    else n_pass++;
    tick(0, 1, 1, 32'hFFFF_FFFF, 1, 32'h11, 1);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || inst !== 32'h77)
      $display("FAIL redir_ack got req=%b addr=%h inst=%h want 1/fffffffc/77", imem_req, imem_addr, inst);
    else n_pass++;
    tick(0, 0, 0, 0, 1, 32'hCAFE, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL wrap got req=%b addr=%h want 1/0", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_reset_in_kill();
    go_req(1);
    tick(0, 1, 1, 32'h60, 0, 0, 1);
    tick(1, 1, 1, 32'h90, 1, 32'h1234, 1);
    n_total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0)
      $display("FAIL rst_kill got req=%b valid=%b pc=%h inst=%h inst_pc=%h want 0/0/0/0/0",
               imem_req, inst_valid, pc, inst, inst_pc);
    else n_pass++;
    tick(0, 0, 0, 0, 1, 32'h5678, 1);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || inst !== 32'h0)
      $display("FAIL rst_release got req=%b addr=%h valid=%b inst=%h want 1/0/0/0",
               imem_req, imem_addr, inst_valid, inst);
    else n_pass++;
  endtask

  task automatic test_random();
    logic rr, bb, zz, ak, rdy;
    tick(1, 0, 0, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 600; i++) begin
      rr  = ($urandom_range(0, 49) == 0);
      bb  = ($urandom_range(0, 1) == 1);
      zz  = ($urandom_range(0, 2) == 0);
      ak  = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 4) != 0);
      tick(rr, bb, zz, $urandom(), ak, $urandom(), rdy);
      n_total++;
      if (imem_req !== m_busy || imem_addr !== m_pc || pc !== m_pc || inst_valid !== m_have ||
          inst !== m_inst || inst_pc !== m_ipc)
        $display("FAIL rand%0d got req=%b addr=%h pc=%h valid=%b inst=%h inst_pc=%h want %b/%h/%h/%b/%h/%h",
                 i, imem_req, imem_addr, pc, inst_valid, inst, inst_pc,
                 m_busy, m_pc, m_pc, m_have, m_inst, m_ipc);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; b = 1'b0; z = 1'b0; b_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    test_reset();
    test_sequential();
    test_delayed_ack();
    test_redirect_hold();
    test_redirect_kill();
    test_no_effect_and_wrap();
    test_reset_in_kill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
